// File: rtl/inst_encoder_if.sv
// -----------------------------------------------------------------------------
// inst_encoder_if
// Purpose : Bundles the field-input handshake, the instruction-memory write
//           port and the status outputs of inst_encoder. Clock and reset are
//           not part of the bundle.
// Signals :
//   i_clear            sync flush / restart at BASE_ADDR
//   i_valid/o_ready    field input handshake
//   i_format (6)       one-hot R/I/S/B/U/J
//   i_kind (2)         I-type variant / U-type LUI vs AUIPC
//   i_rd/i_rs1/i_rs2   register numbers
//   i_funct3, i_b30    funct3 and inst[30]
//   i_imm (32)         sign-extended byte immediate
//   o_mem_wen/o_mem_addr/o_mem_wdata/i_mem_ready   imem write port
//   o_count            words written since reset/clear
//   o_err              sticky illegal-input flag
// Modports: slave = the encoder, master = the producer / memory side.
// -----------------------------------------------------------------------------
interface inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              i_clear;
  logic              i_valid;
  logic              o_ready;
  logic [5:0]        i_format;
  logic [1:0]        i_kind;
  logic [4:0]        i_rd;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [2:0]        i_funct3;
  logic              i_b30;
  logic [31:0]       i_imm;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_count;
  logic              o_err;

  modport slave (
    input  i_clear, i_valid, i_format, i_kind, i_rd, i_rs1, i_rs2,
           i_funct3, i_b30, i_imm, i_mem_ready,
    output o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_err
  );

  modport master (
    output i_clear, i_valid, i_format, i_kind, i_rd, i_rs1, i_rs2,
           i_funct3, i_b30, i_imm, i_mem_ready,
    input  o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_err
  );
endinterface

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Purpose : Packs decoded RV32I instruction fields into 32-bit words, queues
//           them in a small FIFO and writes them to consecutive instruction
//           memory addresses starting at BASE_ADDR.
// Ports   :
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-high reset
//   bus     inst_encoder_if.slave (field handshake, imem write port, status)
// Parameters: DEPTH (FIFO depth, power of 2, >=2), ADDR_W, BASE_ADDR.
// Build option: define ENC_CHECK_EN to reject illegal field combinations and
//   raise the sticky o_err flag; without it fields are truncated and o_err=0.
// -----------------------------------------------------------------------------
module inst_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic           i_clk,
  input logic           i_rst,
  inst_encoder_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic {IDLE, WRITE} state_t;

  // ---------------------------------------------------------------------------
  // Field encoder
  // ---------------------------------------------------------------------------
  logic [31:0] imm;
  logic [31:0] enc_word;
  logic [6:0]  i_op;

  assign imm = bus.i_imm;

  always_comb begin
    case (bus.i_kind)
      2'b01:   i_op = OP_LOAD;
      2'b10:   i_op = OP_JALR;
      default: i_op = OP_IMM;
    endcase
  end

  // Formats are tested in priority order so a non-one-hot format still gives a
  // defined word; an all-zero format yields an all-zero word (opcode 0000000).
  always_comb begin
    enc_word = 32'h0;
    if (bus.i_format[0]) begin
      enc_word = {1'b0, bus.i_b30, 5'b0, bus.i_rs2, bus.i_rs1, bus.i_funct3,
                  bus.i_rd, OP_R};
    end else if (bus.i_format[1]) begin
      enc_word = {imm[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd, i_op};
      // Shift-immediates carry shamt in [24:20] and the arith select in [30].
      if (i_op == OP_IMM && (bus.i_funct3 == 3'b001 || bus.i_funct3 == 3'b101)) begin
        enc_word[31:25] = {1'b0, bus.i_b30, 5'b0};
      end
    end else if (bus.i_format[2]) begin
      enc_word = {imm[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3, imm[4:0], OP_STORE};
    end else if (bus.i_format[3]) begin
      enc_word = {imm[12], imm[10:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                  imm[4:1], imm[11], OP_BR};
    end else if (bus.i_format[4]) begin
      enc_word = {imm[31:12], bus.i_rd, (bus.i_kind[0] ? OP_AUIPC : OP_LUI)};
    end else if (bus.i_format[5]) begin
      enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.i_rd, OP_JAL};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ;
  logic [PTR_W-1:0] rd_idx, rd_next_idx;
  logic             full, empty;
  logic             accept, push, pop, illegal;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;

  assign occ         = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rd_idx      = rd_ptr_q[PTR_W-1:0];
  assign rd_next_idx = rd_idx + PTR_W'(1);

  // Illegal inputs are still consumed from the handshake, just never queued.
  assign accept = bus.i_valid && !full;
  assign push   = accept && !illegal && !bus.i_clear;
  assign pop    = (state_q == WRITE) && bus.i_mem_ready && !bus.i_clear;

  assign wr_ptr_d = bus.i_clear ? '0 : wr_ptr_q + {{PTR_W{1'b0}}, push};
  assign rd_ptr_d = bus.i_clear ? '0 : rd_ptr_q + {{PTR_W{1'b0}}, pop};

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Input legality checks
  // ---------------------------------------------------------------------------
`ifdef ENC_CHECK_EN
  logic i_fits, b_fits, j_fits;
  logic err_q, err_d;

  // A value fits N signed bits when everything above bit N-2 is pure sign.
  assign i_fits = (&imm[31:11]) || !(|imm[31:11]);
  assign b_fits = (&imm[31:12]) || !(|imm[31:12]);
  assign j_fits = (&imm[31:20]) || !(|imm[31:20]);

  assign illegal = !$onehot(bus.i_format)
                 || (bus.i_format[1] && bus.i_kind == 2'b11)
                 || ((bus.i_format[3] || bus.i_format[5]) && imm[0])
                 || ((bus.i_format[1] || bus.i_format[2]) && !i_fits)
                 || (bus.i_format[3] && !b_fits)
                 || (bus.i_format[5] && !j_fits);

  assign err_d = bus.i_clear ? 1'b0 : (err_q || (accept && illegal));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.o_err = err_q;
`else
  assign illegal   = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write-port FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    if (bus.i_clear) begin
      state_d = IDLE;
      addr_d  = BASE_ADDR;
      count_d = '0;
      wdata_d = 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_d = WRITE;
            wdata_d = mem_q[rd_idx];
          end
        end
        WRITE: begin
          if (pop) begin
            addr_d  = addr_q + ADDR_W'(4);
            count_d = count_q + ADDR_W'(1);
            if (occ != (PTR_W+1)'(1)) begin
              wdata_d = mem_q[rd_next_idx];
            end else if (push) begin
              // Last queued word leaves while a new one arrives: forward it,
              // since it is only landing in the array at this same edge.
              wdata_d = enc_word;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= BASE_ADDR;
      count_q  <= '0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.o_ready     = !full;
  assign bus.o_mem_wen   = (state_q == WRITE);
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_count     = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  logic clk;
  logic rst;

  inst_encoder_if #(.ADDR_W(32)) bus ();

  inst_encoder #(
    .DEPTH(4),
    .ADDR_W(32),
    .BASE_ADDR(32'h0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  fmt;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        b30;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  // Writes observed on the imem port: {addr, data}
  logic [63:0] wq [$];

  always @(negedge clk) begin
    if (!rst && !bus.i_clear && bus.o_mem_wen && bus.i_mem_ready) begin
      wq.push_back({bus.o_mem_addr, bus.o_mem_wdata});
      $display("[TB] write addr=%08h data=%08h", bus.o_mem_addr, bus.o_mem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic push(input vec_t v, input string name);
    int n;
    bus.i_format = v.fmt;
    bus.i_kind   = v.kind;
    bus.i_rd     = v.rd;
    bus.i_rs1    = v.rs1;
    bus.i_rs2    = v.rs2;
    bus.i_funct3 = v.f3;
    bus.i_b30    = v.b30;
    bus.i_imm    = v.imm;
    bus.i_valid  = 1'b1;
    n = 0;
    while (!bus.o_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_accept_ready"}, {31'b0, bus.o_ready}, 32'h1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    int c;
    c = 0;
    while (wq.size() < n && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    chk(name, wq.size(), n);
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    @(posedge clk); #1;
    bus.i_clear = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{6'b000001, 2'd0, 5'd3,  5'd1, 5'd2, 3'd0, 1'b0, 32'h0000_0000, 32'h002081B3}; // add
    vecs[1]  = '{6'b000001, 2'd0, 5'd3,  5'd1, 5'd2, 3'd0, 1'b1, 32'h0000_0000, 32'h402081B3}; // sub
    vecs[2]  = '{6'b001000, 2'd0, 5'd0,  5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFF8, 32'hFE208CE3}; // beq -8
    vecs[3]  = '{6'b010000, 2'd0, 5'd5,  5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 32'h123452B7}; // lui
    vecs[4]  = '{6'b000010, 2'd0, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0005, 32'h00500093}; // addi
    vecs[5]  = '{6'b000010, 2'd1, 5'd2,  5'd1, 5'd0, 3'd2, 1'b0, 32'h0000_0008, 32'h0080A103}; // lw
    vecs[6]  = '{6'b000010, 2'd2, 5'd1,  5'd5, 5'd0, 3'd0, 1'b0, 32'h0000_0000, 32'h000280E7}; // jalr
    vecs[7]  = '{6'b000010, 2'd0, 5'd3,  5'd4, 5'd0, 3'd5, 1'b1, 32'h0000_0003, 32'h40325193}; // srai
    vecs[8]  = '{6'b000100, 2'd0, 5'd0,  5'd1, 5'd2, 3'd2, 1'b0, 32'h0000_000C, 32'h0020A623}; // sw
    vecs[9]  = '{6'b010000, 2'd1, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_1000, 32'h00001517}; // auipc
    vecs[10] = '{6'b100000, 2'd0, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0010, 32'h010000EF}; // jal 16
    vecs[11] = '{6'b000010, 2'd0, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFF00093}; // addi -1

    rst = 1'b1;
    bus.i_clear = 1'b0;  bus.i_valid = 1'b0;  bus.i_format = '0;
    bus.i_kind = '0;     bus.i_rd = '0;       bus.i_rs1 = '0;
    bus.i_rs2 = '0;      bus.i_funct3 = '0;   bus.i_b30 = 1'b0;
    bus.i_imm = '0;      bus.i_mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_wen",   {31'b0, bus.o_mem_wen}, 32'h0);
    chk("rst_addr",  bus.o_mem_addr, 32'h0);
    chk("rst_wdata", bus.o_mem_wdata, 32'h0);
    chk("rst_count", bus.o_count, 32'h0);
    chk("rst_err",   {31'b0, bus.o_err}, 32'h0);
    chk("rst_ready", {31'b0, bus.o_ready}, 32'h1);

    // Table: back-to-back stream with memory always ready
    for (int i = 0; i < NV; i++) push(vecs[i], $sformatf("vec%0d", i));
    wait_writes(NV, "table_nwrites");
    for (int i = 0; i < NV && i < wq.size(); i++) begin
      chk($sformatf("vec%0d_data", i), wq[i][31:0], vecs[i].exp);
      chk($sformatf("vec%0d_addr", i), wq[i][63:32], 32'(4 * i));
    end
    chk("table_count", bus.o_count, 32'(NV));
    chk("table_addr",  bus.o_mem_addr, 32'(4 * NV));

    // Back-pressure: fill the FIFO while the memory stalls
    pulse_clear();
    chk("clr_addr",  bus.o_mem_addr, 32'h0);
    chk("clr_count", bus.o_count, 32'h0);
    wq.delete();
    bus.i_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(vecs[i], $sformatf("bp%0d", i));
    chk("bp_full_ready", {31'b0, bus.o_ready}, 32'h0);
    chk("bp_wen", {31'b0, bus.o_mem_wen}, 32'h1);
    bus.i_format = vecs[4].fmt; bus.i_kind = vecs[4].kind; bus.i_rd = vecs[4].rd;
    bus.i_rs1 = vecs[4].rs1;    bus.i_rs2 = vecs[4].rs2;   bus.i_funct3 = vecs[4].f3;
    bus.i_b30 = vecs[4].b30;    bus.i_imm = vecs[4].imm;   bus.i_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_addr%0d", c),  bus.o_mem_addr, 32'h0);
      chk($sformatf("bp_hold_data%0d", c),  bus.o_mem_wdata, vecs[0].exp);
      chk($sformatf("bp_hold_ready%0d", c), {31'b0, bus.o_ready}, 32'h0);
    end
    bus.i_mem_ready = 1'b1;
    push(vecs[4], "bp4");
    wait_writes(5, "bp_nwrites");
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      chk($sformatf("bp%0d_data", i), wq[i][31:0], vecs[i].exp);
      chk($sformatf("bp%0d_addr", i), wq[i][63:32], 32'(4 * i));
    end
    chk("bp_count", bus.o_count, 32'd5);

    // Asynchronous reset in the middle of a stalled write
    bus.i_mem_ready = 1'b0;
    push(vecs[5], "rstw");
    @(posedge clk); #1;
    chk("rstw_wen_before",  {31'b0, bus.o_mem_wen}, 32'h1);
    chk("rstw_addr_before", bus.o_mem_addr, 32'd20);
    #2 rst = 1'b1;
    #1;
    chk("rstw_wen",   {31'b0, bus.o_mem_wen}, 32'h0);
    chk("rstw_addr",  bus.o_mem_addr, 32'h0);
    chk("rstw_ready", {31'b0, bus.o_ready}, 32'h1);
    chk("rstw_count", bus.o_count, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstw_dropped", wq.size(), 32'd5);

    // Two words after reset, then clear while a write is pending
    push(vecs[0], "c0");
    push(vecs[1], "c1");
    wait_writes(7, "clr_nwrites");
    if (wq.size() >= 7) begin
      chk("c0_data", wq[5][31:0], 32'h002081B3);
      chk("c0_addr", wq[5][63:32], 32'h0);
      chk("c1_data", wq[6][31:0], 32'h402081B3);
      chk("c1_addr", wq[6][63:32], 32'h4);
    end
    chk("c_count", bus.o_count, 32'd2);
    bus.i_mem_ready = 1'b0;
    push(vecs[2], "c2");
    @(posedge clk); #1;
    chk("c2_wen",  {31'b0, bus.o_mem_wen}, 32'h1);
    chk("c2_addr", bus.o_mem_addr, 32'h8);
    push(vecs[3], "c3");
    pulse_clear();
    chk("cl_wen",   {31'b0, bus.o_mem_wen}, 32'h0);
    chk("cl_addr",  bus.o_mem_addr, 32'h0);
    chk("cl_count", bus.o_count, 32'h0);
    chk("cl_ready", {31'b0, bus.o_ready}, 32'h1);
    bus.i_mem_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("cl_flushed", wq.size(), 32'd7);

`ifdef ENC_CHECK_EN
    begin
      vec_t bad;
      bad = '{6'b100000, 2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0001, 32'h0};
      push(bad, "jodd");
      repeat (3) begin @(posedge clk); #1; end
      chk("jodd_err",     {31'b0, bus.o_err}, 32'h1);
      chk("jodd_nowrite", wq.size(), 32'd7);
      pulse_clear();
      chk("jodd_clr_err",  {31'b0, bus.o_err}, 32'h0);
      chk("jodd_clr_addr", bus.o_mem_addr, 32'h0);
    end
`else
    begin
      vec_t zf;
      zf = '{6'b000000, 2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 32'h0000_0004, 32'h0};
      push(zf, "zfmt");
      wait_writes(8, "zfmt_nwrites");
      if (wq.size() >= 8) chk("zfmt_opcode", {25'b0, wq[7][6:0]}, 32'h0);
      chk("zfmt_err", {31'b0, bus.o_err}, 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
